// File: rtl/vga_pixel_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module  : vga_pixel_cmd_writer
// Brief   : Buffers (x, y, value) pixel commands and replays each one as the
//           five-register Avalon-MM write sequence of the vga_pixel slave.
// Revision: 1.0 - initial release
// ============================================================================
module vga_pixel_cmd_writer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [8:0] cmd_y,
    input  logic [7:0] cmd_value,
    output logic       avm_chipselect,
    output logic       avm_write,
    output logic [2:0] avm_address,
    output logic [7:0] avm_writedata,
    input  logic       avm_waitrequest,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_HHI  = 3'd1,
        W_HLO  = 3'd2,
        W_VHI  = 3'd3,
        W_VLO  = 3'd4,
        W_VAL  = 3'd5,
        SETTLE = 3'd6
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] value;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic          write_q, write_d;
    logic [2:0]    address_q, address_d;
    logic [7:0]    writedata_q, writedata_d;

    logic full, push, pop;
    cmd_t head;

    always_comb begin
        full         = (count_q == FULL_CNT);
        push         = cmd_valid && !full;
        pop          = 1'b0;
        head         = mem_q[rd_ptr_q];
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        cmd_d        = cmd_q;
        settle_d     = settle_q;
        drop_count_d = drop_count_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head.x > 10'd639 || head.y > 9'd479) begin
                        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
                    end else begin
                        cmd_d   = head;
                        state_d = W_HHI;
                    end
                end
            end
            W_HHI: if (!avm_waitrequest) state_d = W_HLO;
            W_HLO: if (!avm_waitrequest) state_d = W_VHI;
            W_VHI: if (!avm_waitrequest) state_d = W_VLO;
            W_VLO: if (!avm_waitrequest) state_d = W_VAL;
            W_VAL: begin
                if (!avm_waitrequest) begin
                    if (SETTLE_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_LAST;
                    end
                end
            end
            SETTLE: begin
                if (settle_q == '0) state_d = IDLE;
                else                settle_d = settle_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_d] = '{x: cmd_x, y: cmd_y, value: cmd_value};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Bus outputs follow the next state so they are registered alongside it;
        // a stalled state re-registers identical address/data.
        write_d     = 1'b1;
        address_d   = 3'd0;
        writedata_d = 8'd0;
        case (state_d)
            W_HHI: begin address_d = 3'd3; writedata_d = {6'b0, cmd_d.x[9:8]}; end
            W_HLO: begin address_d = 3'd4; writedata_d = cmd_d.x[7:0];         end
            W_VHI: begin address_d = 3'd5; writedata_d = {7'b0, cmd_d.y[8]};   end
            W_VLO: begin address_d = 3'd6; writedata_d = cmd_d.y[7:0];         end
            W_VAL: begin address_d = 3'd0; writedata_d = cmd_d.value;          end
            default: write_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            cmd_q        <= '0;
            settle_q     <= '0;
            drop_count_q <= '0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            settle_q     <= settle_d;
            drop_count_q <= drop_count_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
        end
    end

    assign cmd_ready      = !full;
    assign avm_write      = write_q;
    assign avm_chipselect = write_q;
    assign avm_address    = address_q;
    assign avm_writedata  = writedata_q;
    assign busy           = (count_q != '0) || (state_q != IDLE);
    assign drop_count     = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_pixel_cmd_writer
// Brief   : Scoreboard bench: expected bus words queued at command accept and
//           popped on every completed Avalon write.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_pixel_cmd_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x = '0;
    logic [8:0] cmd_y = '0;
    logic [7:0] cmd_value = '0;
    logic       avm_chipselect, avm_write;
    logic [2:0] avm_address;
    logic [7:0] avm_writedata;
    logic       avm_waitrequest = 1'b0;
    logic       busy;
    logic [7:0] drop_count;

    vga_pixel_cmd_writer #(.DEPTH(4), .SETTLE_CYC(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_value(cmd_value),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [10:0] exp_q [$];
    logic [10:0] exp_w, prev_word;
    logic        stalled_prev = 1'b0;
    bit          mon_en = 1'b0;
    int          n_checks = 0, n_errors = 0, cnt5 = 0, exp_drop = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one command starting just after a clock edge; returns #1 after the accept edge.
    task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [7:0] v,
                        output bit waited);
        int guard = 0;
        waited    = 1'b0;
        cmd_x     = x;
        cmd_y     = y;
        cmd_value = v;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 200) begin
            waited = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            check_val("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        if (x <= 10'd639 && y <= 9'd479) begin
            exp_q.push_back({3'd3, 6'b0, x[9:8]});
            exp_q.push_back({3'd4, x[7:0]});
            exp_q.push_back({3'd5, 7'b0, y[8]});
            exp_q.push_back({3'd6, y[7:0]});
            exp_q.push_back({3'd0, v});
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy || exp_q.size() != 0) && g < 500);
        check_val("idle_busy", busy, 0);
        check_val("idle_drain", exp_q.size(), 0);
    endtask

    task automatic wait_bus_addr(input logic [2:0] a, input string tag);
        int g = 0;
        while (!(avm_write && avm_address == a) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check_val(tag, {avm_write, avm_address}, {1'b1, a});
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (avm_write) begin
                if (avm_address == 3'd5) cnt5++;
                check_val("chipselect", avm_chipselect, 1);
                if (stalled_prev) check_val("stall_hold", {avm_address, avm_writedata}, prev_word);
                if (!avm_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        check_val("write_expected", avm_write, 0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check_val("write_word", {avm_address, avm_writedata}, exp_w);
                    end
                end
                stalled_prev = avm_waitrequest;
                prev_word    = {avm_address, avm_writedata};
            end else begin
                stalled_prev = 1'b0;
                check_val("idle_bus", {avm_chipselect, avm_address, avm_writedata}, 0);
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit w;
        bit waits [7];

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_write", {avm_write, avm_chipselect}, 0);
        check_val("rst_bus", {avm_address, avm_writedata}, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_drop", drop_count, 0);
        check_val("rst_ready", cmd_ready, 1);
        mon_en = 1'b1;

        // Single command: latency, back-to-back writes, settle gap
        send(10'd300, 9'd200, 8'hFF, w);
        @(negedge clk);
        check_val("t1_latency", avm_write, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t1_burst", avm_write, 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t1_settle", {busy, avm_write}, 2'b10);
        end
        @(negedge clk);
        check_val("t1_busy_drop", busy, 0);

        // FIFO fill: ready must fall only after the fifth accept
        for (int i = 0; i < 7; i++) begin
            send(10'(i * 50 + 10), 9'(i * 30 + 5), 8'(i + 1), w);
            waits[i] = w;
        end
        for (int i = 0; i < 5; i++) check_val("t2_no_wait", waits[i], 0);
        check_val("t2_backpressure", waits[5], 1);
        wait_idle();

        // Stall during the vertical-high write
        cnt5 = 0;
        send(10'd100, 9'd300, 8'h55, w);
        wait_bus_addr(3'd5, "t3_reach_vhi");
        avm_waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        wait_idle();
        check_val("t3_hold_cycles", cnt5, 4);

        // Out-of-range drop then the corner pixel
        send(10'd640, 9'd0, 8'h11, w);
        repeat (3) @(negedge clk);
        check_val("t4_drop", drop_count, exp_drop);
        check_val("t4_no_busy", busy, 0);
        send(10'd639, 9'd479, 8'h80, w);
        wait_idle();

        // Reset mid-sequence with two commands queued
        send(10'd10, 9'd10, 8'h01, w);
        send(10'd20, 9'd20, 8'h02, w);
        send(10'd30, 9'd30, 8'h03, w);
        wait_bus_addr(3'd6, "t5_reach_vlo");
        reset = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("t5_write", avm_write, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_ready", cmd_ready, 1);
        check_val("t5_drop", drop_count, 0);
        send(10'd5, 9'd6, 8'h07, w);
        wait_idle();

        // Drop counter saturation
        for (int i = 0; i < 300; i++) send(10'(i), 9'd480, 8'(i), w);
        repeat (4) @(negedge clk);
        check_val("t6_drop_sat", drop_count, exp_drop);
        check_val("t6_drop_255", drop_count, 255);
        wait_idle();

        check_val("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
